// File: rtl/sin_table_loader.sv
// Writer for the external quarter-sine SRAM: assembles little-endian byte pairs into
// 16-bit words and writes them with programmable setup/strobe/hold timing; lends the bus to the DDS when idle.
module sin_table_loader #(
    parameter int DEPTH     = 65536,
    parameter int SETUP_CYC = 1,
    parameter int WE_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [15:0] dds_addr,
    output logic [15:0] dds_data,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        SETUP = 3'd3,
        WRITE = 3'd4,
        HOLD  = 3'd5
    } state_t;

    localparam int CNT_W = 8;
    localparam logic [15:0]      LAST_ADDR  = 16'(DEPTH - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WE_LOAD    = CNT_W'(WE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [15:0]      addr_reg;
    logic [15:0]      data_reg;
    logic [15:0]      checksum_reg;
    logic [7:0]       low_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             ready_reg;
    logic             we_n_reg;
    logic             oe_n_reg;
    logic             dq_oe_reg;

    logic        xfer;
    logic [15:0] word_next;

    assign xfer      = byte_valid & ready_reg;
    assign word_next = {byte_in, low_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            checksum_reg <= '0;
            low_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ready_reg    <= 1'b0;
            we_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b0;
            dq_oe_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= LO;
                        busy_reg     <= 1'b1;
                        done_reg     <= 1'b0;
                        checksum_reg <= '0;
                        addr_reg     <= '0;
                        ready_reg    <= 1'b1;
                        oe_n_reg     <= 1'b1;
                        dq_oe_reg    <= 1'b1;
                    end
                end
                LO: begin
                    if (xfer) begin
                        low_reg   <= byte_in;
                        state_reg <= HI;
                    end
                end
                HI: begin
                    if (xfer) begin
                        data_reg     <= word_next;
                        checksum_reg <= checksum_reg + word_next;
                        ready_reg    <= 1'b0;
                        cnt_reg      <= SETUP_LOAD;
                        state_reg    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg == '0) begin
                        we_n_reg  <= 1'b0;
                        cnt_reg   <= WE_LOAD;
                        state_reg <= WRITE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt_reg == '0) begin
                        we_n_reg  <= 1'b1;
                        cnt_reg   <= HOLD_LOAD;
                        state_reg <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (addr_reg == LAST_ADDR) begin
                        // Release the bus: driver off and read enable on, same edge.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        dq_oe_reg <= 1'b0;
                        oe_n_reg  <= 1'b0;
                    end else begin
                        addr_reg  <= addr_reg + 16'd1;
                        ready_reg <= 1'b1;
                        state_reg <= LO;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // DDS read path is a pure pass-through while idle; muted while the loader owns the bus.
    assign sram_addr   = busy_reg ? addr_reg : dds_addr;
    assign dds_data    = busy_reg ? 16'd0 : sram_dq_in;

    assign sram_dq_out = data_reg;
    assign sram_dq_oe  = dq_oe_reg;
    assign sram_ce_n   = 1'b0;
    assign sram_oe_n   = oe_n_reg;
    assign sram_we_n   = we_n_reg;
    assign byte_ready  = ready_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign checksum    = checksum_reg;

    a_no_bus_fight: assert property (@(posedge clk) disable iff (rst)
        !(sram_dq_oe && !sram_oe_n));

    a_ready_only_loading: assert property (@(posedge clk) disable iff (rst)
        byte_ready |-> (state_reg == LO || state_reg == HI));

endmodule

// File: tb/tb_sin_table_loader.sv
// Directed bench for sin_table_loader with a 4-word table and a behavioural async SRAM.
module tb_sin_table_loader;

    localparam int DEPTH     = 4;
    localparam int SETUP_CYC = 1;
    localparam int WE_CYC    = 2;
    localparam int HOLD_CYC  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] dds_addr;
    logic [15:0] dds_data;
    logic [15:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    sin_table_loader #(
        .DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC), .WE_CYC(WE_CYC), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .dds_addr(dds_addr), .dds_data(dds_data),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:DEPTH-1];
    logic        use_mem;
    logic [15:0] fixed_val;
    logic [7:0]  stream [0:7];
    logic [15:0] exp_img [0:DEPTH-1];

    always_comb begin
        sram_dq_in = fixed_val;
        if (sram_dq_oe === 1'b1)
            sram_dq_in = sram_dq_out;
        else if (use_mem && sram_addr < 16'(DEPTH))
            sram_dq_in = mem[sram_addr[1:0]];
    end

    longint cyc = 0;
    always @(posedge clk) cyc++;

    // Bus monitor: commits writes on WE# rising and tallies timing violations.
    logic        we_prev = 1'b1;
    int          low_cnt = 0;
    bit          in_win = 1'b0;
    int          win_len = 0;
    logic [15:0] ref_addr, ref_data;
    int          we_len_viol = 0, stab_viol = 0, bus_viol = 0, ready_viol = 0, win_viol = 0;
    logic [15:0] wr_log [$];

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            low_cnt = 0;
            in_win  = 1'b0;
            we_prev = 1'b1;
        end else begin
            if (sram_dq_oe === 1'b1 && sram_oe_n === 1'b0) bus_viol++;
            if (byte_ready === 1'b1 && sram_we_n === 1'b0) ready_viol++;
            if (busy === 1'b1 && byte_ready === 1'b0) begin
                if (!in_win) begin
                    in_win   = 1'b1;
                    win_len  = 1;
                    ref_addr = sram_addr;
                    ref_data = sram_dq_out;
                end else begin
                    win_len++;
                    if (sram_addr !== ref_addr || sram_dq_out !== ref_data) stab_viol++;
                end
            end else if (in_win) begin
                in_win = 1'b0;
                if (win_len != SETUP_CYC + WE_CYC + HOLD_CYC) win_viol++;
            end
            if (sram_we_n === 1'b0) low_cnt++;
            if (we_prev === 1'b0 && sram_we_n === 1'b1) begin
                if (low_cnt != WE_CYC) we_len_viol++;
                mem[sram_addr[1:0]] = sram_dq_out;
                wr_log.push_back(sram_addr);
                $display("write addr=%0d data=%04h low_clks=%0d", sram_addr, sram_dq_out, low_cnt);
                low_cnt = 0;
            end
            we_prev = sram_we_n;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
        wr_log.delete();
    endtask

    task automatic send_bytes(input int n, input int max_gap, input int start_at);
        for (int i = 0; i < n; i++) begin
            int gap;
            int wait_n;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
            byte_valid = 1'b1;
            byte_in    = stream[i];
            if (i == start_at) start = 1'b1;
            wait_n = 0;
            while (byte_ready !== 1'b1 && wait_n < 50) begin
                @(negedge clk);
                wait_n++;
            end
            checks++;
            if (wait_n >= 50) begin
                errors++;
                $display("FAIL byte_handshake byte=%0d ready=%b required ready=1 within 50 clks", i, byte_ready);
            end
            @(negedge clk);
            start = 1'b0;
        end
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input int max_gap, input int start_at, output longint dur);
        longint t0;
        int     n;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        send_bytes(8, max_gap, start_at);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL load_timeout busy=%b required busy=0 within 200 clks", busy);
        end
        dur = cyc - t0;
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (mem[i] !== exp_img[i]) begin
                errors++;
                $display("FAIL %s_mem[%0d] got=%04h exp=%04h", tag, i, mem[i], exp_img[i]);
            end
        end
        checks++;
        if (checksum !== 16'h0005) begin
            errors++;
            $display("FAIL %s_checksum got=%04h exp=0005", tag, checksum);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got done=%b busy=%b exp done=1 busy=0", tag, done, busy);
        end
        checks++;
        if (wr_log.size() != DEPTH) begin
            errors++;
            $display("FAIL %s_write_count got=%0d exp=%0d", tag, wr_log.size(), DEPTH);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sram_we_n, sram_dq_oe, busy, done, byte_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got we_n/dq_oe/busy/done/ready=%b exp=10000",
                     {sram_we_n, sram_dq_oe, busy, done, byte_ready});
        end
        checks++;
        if ({sram_ce_n, sram_oe_n} !== 2'b00 || checksum !== 16'h0 || sram_dq_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus got ce_n=%b oe_n=%b checksum=%04h dq_out=%04h exp 0/0/0000/0000",
                     sram_ce_n, sram_oe_n, checksum, sram_dq_out);
        end
        rst = 1'b0;
        use_mem = 1'b0;
        fixed_val = 16'hBEEF;
        dds_addr = 16'h1234;
        #1;
        checks++;
        if (sram_addr !== 16'h1234) begin
            errors++;
            $display("FAIL idle_addr_pass got=%04h exp=1234", sram_addr);
        end
        checks++;
        if (dds_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL idle_data_pass got=%04h exp=BEEF", dds_data);
        end
        @(negedge clk);
    endtask

    task automatic test_full_load();
        longint dur;
        clear_mem();
        run_load(0, -1, dur);
        check_image("full");
        checks++;
        if (dur != 25) begin
            errors++;
            $display("FAIL full_duration got=%0d exp=25", dur);
        end
        checks++;
        if (sram_dq_oe !== 1'b0 || sram_oe_n !== 1'b0) begin
            errors++;
            $display("FAIL full_turnaround got dq_oe=%b oe_n=%b exp 0/0", sram_dq_oe, sram_oe_n);
        end
        use_mem = 1'b1;
        dds_addr = 16'd2;
        #1;
        checks++;
        if (dds_data !== 16'h0003) begin
            errors++;
            $display("FAIL full_readback got=%04h exp=0003", dds_data);
        end
        use_mem = 1'b0;
        dds_addr = 16'h1234;
        @(negedge clk);
    endtask

    task automatic test_write_timing();
        checks++;
        if (we_len_viol != 0) begin
            errors++;
            $display("FAIL we_pulse_width got=%0d bad pulses exp=0", we_len_viol);
        end
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL addr_data_stable got=%0d unstable clks exp=0", stab_viol);
        end
        checks++;
        if (bus_viol != 0) begin
            errors++;
            $display("FAIL bus_fight got=%0d clks with dq_oe=1 and oe_n=0 exp=0", bus_viol);
        end
        checks++;
        if (win_viol != 0 || ready_viol != 0) begin
            errors++;
            $display("FAIL write_window got win=%0d ready=%0d violations exp=0/0", win_viol, ready_viol);
        end
    endtask

    task automatic test_backpressure();
        longint dur;
        clear_mem();
        run_load(5, -1, dur);
        check_image("stall");
    endtask

    task automatic test_abort();
        longint dur;
        int     n;
        clear_mem();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_bytes(6, 0, -1);
        n = 0;
        while (!(sram_we_n === 1'b0 && sram_addr === 16'd2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL abort_reach_write got we_n=%b addr=%0d exp we_n=0 addr=2", sram_we_n, sram_addr);
        end
        checks++;
        if (dds_data !== 16'h0 || sram_addr !== 16'd2) begin
            errors++;
            $display("FAIL busy_mute got dds_data=%04h sram_addr=%04h exp 0000/0002", dds_data, sram_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({sram_we_n, sram_dq_oe, busy, done, byte_ready} !== 5'b10000 || checksum !== 16'h0) begin
            errors++;
            $display("FAIL abort_state got we_n/dq_oe/busy/done/ready=%b checksum=%04h exp 10000/0000",
                     {sram_we_n, sram_dq_oe, busy, done, byte_ready}, checksum);
        end
        rst = 1'b0;
        @(negedge clk);
        clear_mem();
        run_load(0, -1, dur);
        check_image("reload");
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (wr_log[i] !== 16'(i)) begin
                errors++;
                $display("FAIL reload_addr_seq[%0d] got=%0d exp=%0d", i, wr_log[i], i);
            end
        end
    endtask

    task automatic test_start_while_busy();
        longint dur;
        clear_mem();
        run_load(0, 3, dur);
        check_image("restart");
        checks++;
        if (dur != 25) begin
            errors++;
            $display("FAIL restart_duration got=%0d exp=25", dur);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (wr_log[i] !== 16'(i)) begin
                errors++;
                $display("FAIL restart_addr_seq[%0d] got=%0d exp=%0d", i, wr_log[i], i);
            end
        end
    endtask

    task automatic test_rst_start();
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, byte_ready, sram_dq_oe, done} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_start got busy/ready/dq_oe/done=%b exp=0000", {busy, byte_ready, sram_dq_oe, done});
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_after got busy=%b exp=0", busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        dds_addr = 16'h0;
        use_mem = 1'b0;
        fixed_val = 16'h0;
        stream[0] = 8'h01; stream[1] = 8'h00; stream[2] = 8'h02; stream[3] = 8'h00;
        stream[4] = 8'h03; stream[5] = 8'h00; stream[6] = 8'hFF; stream[7] = 8'hFF;
        exp_img[0] = 16'h0001; exp_img[1] = 16'h0002;
        exp_img[2] = 16'h0003; exp_img[3] = 16'hFFFF;

        test_reset();
        test_full_load();
        test_write_timing();
        test_backpressure();
        test_abort();
        test_start_while_busy();
        test_rst_start();
        test_write_timing();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
